// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel feeder: command codes, colour field
// widths and the feeder FSM state encoding.
package vga_pkg;

    localparam int R_W     = 2;
    localparam int G_W     = 2;
    localparam int B_W     = 2;
    localparam int RGB_W   = R_W + G_W + B_W;
    localparam int ENTRY_W = RGB_W + 1;

    localparam logic [1:0] CMD_PIX = 2'b00;
    localparam logic [1:0] CMD_RST = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/pix_fifo.sv
// Synchronous pixel FIFO with occupancy output; a written entry only becomes
// visible at the head one cycle later because emptiness tracks the registered level.
module pix_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 7,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = AW + 1
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_pix) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly AW bits wide, so the power-of-two depth makes them wrap naturally.
    always_ff @(posedge clk_pix or negedge rst_pix) begin
        if (!rst_pix) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/vga_pixel_feeder.sv
// Buffers upstream pixels and feeds them to the VGA driver as command/colour
// bytes, aligning to frame starts and flagging underflow and misplaced sof.
module vga_pixel_feeder
    import vga_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RGB_W-1:0] in_rgb,
    input  logic             in_sof,
    input  logic             de,
    output logic [7:0]       wb_data,
    output logic [LVL_W-1:0] level,
    output logic             underflow,
    output logic             sof_err,
    input  logic             clr_flags
);

    feeder_state_t      state;
    feeder_state_t      state_nxt;
    logic [ENTRY_W-1:0] head;
    logic               head_sof;
    logic [RGB_W-1:0]   head_rgb;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [7:0]         wb_nxt;
    logic               first_pix;
    logic               first_nxt;
    logic               set_uf;
    logic               set_se;

    assign in_ready = !fifo_full;
    assign head_sof = head[RGB_W];
    assign head_rgb = head[RGB_W-1:0];

    pix_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .push    (in_valid && in_ready),
        .pop     (pop),
        .wdata   ({in_sof, in_rgb}),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // A misplaced sof pixel is left at the head so the DRAIN state resyncs on it.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        wb_nxt    = 8'h00;
        first_nxt = first_pix;
        set_uf    = 1'b0;
        set_se    = 1'b0;
        case (state)
            IDLE, DRAIN: begin
                if (!fifo_empty) begin
                    if (head_sof) begin
                        state_nxt = SYNC;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            SYNC: begin
                wb_nxt    = {6'b00_0000, CMD_RST};
                first_nxt = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (de) begin
                    if (fifo_empty) begin
                        set_uf    = 1'b1;
                        state_nxt = DRAIN;
                    end else if (head_sof && !first_pix) begin
                        set_se    = 1'b1;
                        state_nxt = DRAIN;
                    end else begin
                        pop       = 1'b1;
                        wb_nxt    = {head_rgb, CMD_PIX};
                        first_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_pix or negedge rst_pix) begin
        if (!rst_pix) begin
            state     <= IDLE;
            wb_data   <= 8'h00;
            first_pix <= 1'b0;
            underflow <= 1'b0;
            sof_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            wb_data   <= wb_nxt;
            first_pix <= first_nxt;
            underflow <= clr_flags ? 1'b0 : (underflow | set_uf);
            sof_err   <= clr_flags ? 1'b0 : (sof_err | set_se);
        end
    end

endmodule

// File: doc/vga_pixel_feeder.md
VGA_PIXEL_FEEDER -- requirements
Module: vga_pixel_feeder

Interface
REQ-001 Parameter DEPTH, default 16, pixel FIFO depth in entries; power of two, minimum 4.
REQ-002 clk_pix  in  1  pixel clock; all logic rising-edge.
REQ-003 rst_pix  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  upstream pixel valid.
REQ-005 in_ready  out  1  feeder can accept a pixel; equals !full.
REQ-006 in_rgb  in  6  pixel colour: [5:4] R, [3:2] G, [1:0] B.
REQ-007 in_sof  in  1  marks the pixel as pixel (0,0) of a frame.
REQ-008 de  in  1  data enable from the downstream VGA driver.
REQ-009 wb_data  out  8  driver command/colour byte: [7:6] R, [5:4] G, [3:2] B, [1:0] command (00 = pixel, 11 = counter reset).
REQ-010 level  out  clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 underflow  out  1  sticky flag: a pixel was required while the FIFO was empty.
REQ-012 sof_err  out  1  sticky flag: an sof-marked pixel was popped at a non-frame-start position.
REQ-013 clr_flags  in  1  synchronous clear of underflow and sof_err.

Function
REQ-014 FIFO entry SHALL hold {sof, rgb} (7 bits).
REQ-015 Push SHALL occur when in_valid && in_ready.
REQ-016 No fall-through: a pixel pushed in cycle N SHALL NOT be poppable before cycle N+1.
REQ-017 FSM states SHALL be IDLE, SYNC, RUN and DRAIN.
REQ-018 IDLE: no pops on de; when the FIFO head has sof=1 -> SYNC; when the head has sof=0, pop it and discard it.
REQ-019 SYNC (one cycle): register wb_data = 8'b0000_0011; next state RUN; frame pixel index is reset to 0.
REQ-020 RUN: in each cycle with de=1, pop one entry and register wb_data = {rgb,2'b00} at the following edge (latency 1).
REQ-021 RUN: in a de=0 cycle, wb_data SHALL be 8'h00 and no pop occurs.
REQ-022 RUN, de=1 with the FIFO empty: register wb_data = 8'h00, set underflow, go to DRAIN.
REQ-023 RUN: a popped entry with sof=1 that is not the first pop after SYNC SHALL set sof_err and go to DRAIN; wb_data = 8'h00 for that cycle.
REQ-024 DRAIN: pop and discard every entry until the head has sof=1, then go to SYNC; wb_data = 8'h00 throughout.
REQ-025 A push and a pop in the same cycle SHALL leave level unchanged; pushes are blocked when full, even if a pop occurs in the same cycle.
REQ-026 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or go below 0.
REQ-027 clr_flags SHALL take priority over a same-cycle set event (flag reads 0 the next cycle).
REQ-028 The command 11 SHALL appear on wb_data[1:0] only in the cycle following SYNC.

Reset
REQ-029 On rst_pix low, immediately: state = IDLE, FIFO empty (pointers 0, level 0), wb_data = 8'h00, underflow = 0, sof_err = 0.
REQ-030 Reset mid-frame SHALL discard all buffered pixels; after release, operation restarts from IDLE and waits for the next sof.
REQ-031 in_ready SHALL be 1 during and after reset (FIFO empty).

Structure
REQ-032 Shared package vga_pkg SHALL hold the wb_data command codes (CMD_PIX = 2'b00, CMD_RST = 2'b11), the FSM state enum and the colour field widths.
REQ-033 The FIFO SHALL be a separate sub-module pix_fifo (parameterised DEPTH/WIDTH, level output, no fall-through).
REQ-034 Total RTL SHALL be 120-400 lines.

Verification
REQ-035 After reset, push 4 pixels, the first with sof=1 and rgb 6'h3F -> one cycle of wb_data = 8'h03, then on de=1 wb_data = 8'hFC, 8'h.., in push order.
REQ-036 Fill to DEPTH with no de -> in_ready = 0 and level = 16; a 17th in_valid is not accepted; one de pop restores in_ready = 1.
REQ-037 In RUN with the FIFO empty, hold de = 1 -> underflow = 1, wb_data = 8'h00, and state DRAIN until the next sof pixel; then one SYNC 8'h03.
REQ-038 Stream in which the 3rd pixel has sof=1 -> sof_err = 1, remaining pixels discarded, SYNC issued on the sof pixel.
REQ-039 Assert rst_pix with level = 10 mid-frame -> level = 0 and wb_data = 8'h00 asynchronously; the pre-sof pixels pushed after release are discarded in IDLE.
REQ-040 Simultaneous push and pop at level 5 for 20 cycles -> level stays 5 and output order is preserved across pointer wrap.
